passcode_checker: RTL and testbench
===================================

Name: passcode_checker

Overview:
- Keypad-side front end of the door-lock controller, directly upstream of the lock state manager.
- Accepts decoded key strobes and collects digits into an entry buffer, holding the stored passcode.
- Produces the registered single-cycle pulses the state manager consumes: is_star_pressed, correct, initialize.
- Also owns wrong-attempt counting and a timed lockout.

Parameters:
- CODE_LEN, 4, number of digits in a passcode (1..8)
- DIGIT_W, 4, bits per key code
- DEFAULT_CODE, 16'h1234, passcode loaded at reset, CODE_LEN*DIGIT_W bits, first digit in MSBs
- MAX_FAIL, 3, consecutive wrong submissions that trigger lockout
- LOCK_CYCLES, 1000, lockout duration in clk cycles

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- is_on  in  1  lock powered/awake; keys ignored while 0
- program_en  in  1  state manager is in passcode-change mode
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  DIGIT_W  0-9 digit, 0xA '*', 0xB '#', 0xC-0xF reserved
- is_star_pressed  out  1  one-cycle pulse on accepted '*'
- correct  out  1  one-cycle pulse on matching submission (not in program mode)
- initialize  out  1  one-cycle pulse when a new passcode has been stored
- wrong  out  1  one-cycle pulse on failed submission
- lockout  out  1  high while lockout timer runs
- digit_cnt  out  4  digits currently buffered (0..CODE_LEN), for display

Behaviour:
- Reset (reset=0, async):
  - FSM=ENTRY; buffer=0; digit_cnt=0; overflow=0; fail_cnt=0; lock timer=0.
  - stored=DEFAULT_CODE.
  - All pulse outputs and lockout = 0.
- Latency: every response is registered; key_valid at edge N gives its pulse for exactly the cycle after edge N. No back-to-back pulse merging; each accepted key yields at most one pulse.
- FSM states:
  - ENTRY: normal operation.
  - LOCKED: keys ignored.
- Keys are ignored (no state change, no pulse) when:
  - is_on=0 or FSM=LOCKED;
  - key_code is reserved (0xC-0xF).
- is_on falling edge: buffer, digit_cnt and overflow clear. fail_cnt is kept.
- Digit key:
  - If digit_cnt<CODE_LEN: shift into buffer LSB side, digit_cnt+1.
  - If digit_cnt==CODE_LEN: buffer unchanged, overflow=1.
- '*' key: pulse is_star_pressed; clear buffer/digit_cnt/overflow. fail_cnt unchanged.
- '#' key, valid submission (digit_cnt==CODE_LEN and overflow=0):
  - program_en=1: stored<=buffer, pulse initialize, fail_cnt=0.
  - program_en=0 and buffer==stored: pulse correct, fail_cnt=0.
- '#' key, any other case: pulse wrong. In program mode the stored passcode is unchanged and fail_cnt is not incremented.
- '#' key, wrong in normal mode: fail_cnt+1. When the incremented value equals MAX_FAIL:
  - FSM=LOCKED, lockout=1 on the same cycle as the wrong pulse;
  - timer loaded with LOCK_CYCLES-1.
- After every '#': buffer, digit_cnt and overflow clear.
- LOCKED:
  - Timer decrements each cycle. At 0, FSM=ENTRY, lockout=0, fail_cnt=0.
  - Lockout lasts exactly LOCK_CYCLES cycles.
  - is_on low does not cancel the lockout.
- Widths:
  - fail_cnt is $clog2(MAX_FAIL+1) bits, saturating.
  - Timer is $clog2(LOCK_CYCLES) bits.
  - Comparison covers the full CODE_LEN*DIGIT_W bits.
- Reset asserted mid-entry or mid-lockout aborts everything. The stored passcode reverts to DEFAULT_CODE (no non-volatile storage).

Decomposition:
- Shared package lock_pkg:
  - key code constants: KEY_STAR=4'hA, KEY_HASH=4'hB;
  - FSM state encoding: ENTRY, LOCKED;
  - DEFAULT_CODE.
- One natural sub-module: lockout_timer (load, count-down, done pulse). Buffer/compare logic stays in the parent.

Test Plan:
- Reset, keys 1,2,3,4,# with program_en=0 -> correct=1 for one cycle, the cycle after '#'; wrong, initialize stay 0; digit_cnt returns to 0.
- Keys 1,2,3,#, then 1,2,3,4,5,# -> wrong pulses twice (short entry, then overflow); fail_cnt=2; correct never asserts.
- Three wrong submissions -> lockout rises with the third wrong pulse and stays high exactly LOCK_CYCLES cycles. Digits pressed during lockout are ignored. Afterwards 1,2,3,4,# -> correct.
- program_en=1, keys 9,8,7,6,# -> initialize pulse. Then program_en=0: 1,2,3,4,# -> wrong; 9,8,7,6,# -> correct.
- Keys 5,6,*, then 1,2,3,4,# -> is_star_pressed pulse after '*', digit_cnt 2->0, then correct.
- Reset driven low mid-entry after 1,2 and mid-lockout -> all outputs 0 immediately (async); stored reverts to 16'h1234. Keys with is_on=0 produce no pulses.

Source files
------------

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared key codes, lock FSM encoding and factory passcode
package lock_pkg;

  // Key codes carried on key_code; 0-9 are digits, 0xC-0xF are reserved
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  // Lock FSM encoding
  localparam logic [0:0] ENTRY  = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Passcode loaded on every reset, first digit in the MSBs
  localparam logic [15:0] DEFAULT_CODE = 16'h1234;

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - loadable down-counter timing the wrong-attempt lockout
module lockout_timer #(
  parameter int LOCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [TW-1:0] count;
  logic          running;

  // Load LOCK_CYCLES-1 and count down to zero; done marks the final locked cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= TW'(LOCK_CYCLES - 1);
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = running && (count == '0);

endmodule

// File: rtl/passcode_checker.sv
// rtl/passcode_checker.sv - keypad digit collection, passcode compare/program and lockout
module passcode_checker #(
  parameter int                          CODE_LEN     = 4,
  parameter int                          DIGIT_W      = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = (CODE_LEN*DIGIT_W)'(lock_pkg::DEFAULT_CODE),
  parameter int                          MAX_FAIL     = 3,
  parameter int                          LOCK_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               is_on,
  input  logic               program_en,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  output logic               is_star_pressed,
  output logic               correct,
  output logic               initialize,
  output logic               wrong,
  output logic               lockout,
  output logic [3:0]         digit_cnt
);

  localparam int W      = CODE_LEN * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic [0:0]        state;
  logic [W-1:0]      entry_buf;
  logic [W-1:0]      stored;
  logic [3:0]        cnt;
  logic              overflow;
  logic [FAIL_W-1:0] fail_cnt;
  logic              on_q;

  logic              key_ok;
  logic              is_digit;
  logic              is_star;
  logic              is_hash;
  logic              sub_ok;
  logic              match;
  logic [FAIL_W-1:0] fail_next;
  logic              lock_now;
  logic              lock_done;

  // Qualify the key strobe and decode what a '#' right now would mean
  always_comb begin
    key_ok    = key_valid && is_on && (state == lock_pkg::ENTRY) && (key_code < DIGIT_W'(12));
    is_digit  = key_code < DIGIT_W'(10);
    is_star   = key_code == DIGIT_W'(lock_pkg::KEY_STAR);
    is_hash   = key_code == DIGIT_W'(lock_pkg::KEY_HASH);
    sub_ok    = (cnt == 4'(CODE_LEN)) && !overflow;
    match     = entry_buf == stored;
    fail_next = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
    lock_now  = key_ok && is_hash && !program_en && !(sub_ok && match)
                && (fail_next == FAIL_W'(MAX_FAIL));
  end

  // Entry buffer, stored passcode, fail count, lock FSM and the registered pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= lock_pkg::ENTRY;
      entry_buf       <= '0;
      stored          <= DEFAULT_CODE;
      cnt             <= '0;
      overflow        <= 1'b0;
      fail_cnt        <= '0;
      on_q            <= 1'b0;
      is_star_pressed <= 1'b0;
      correct         <= 1'b0;
      initialize      <= 1'b0;
      wrong           <= 1'b0;
    end else begin
      is_star_pressed <= 1'b0;
      correct         <= 1'b0;
      initialize      <= 1'b0;
      wrong           <= 1'b0;
      on_q            <= is_on;

      if ((state == lock_pkg::LOCKED) && lock_done) begin
        state    <= lock_pkg::ENTRY;
        fail_cnt <= '0;
      end

      // Powering down discards a half-typed entry but remembers failures
      if (on_q && !is_on) begin
        entry_buf <= '0;
        cnt       <= '0;
        overflow  <= 1'b0;
      end

      if (key_ok) begin
        if (is_digit) begin
          if (cnt < 4'(CODE_LEN)) begin
            entry_buf <= (entry_buf << DIGIT_W) | W'(key_code);
            cnt       <= cnt + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          // '*' and '#' both end the current entry
          entry_buf <= '0;
          cnt       <= '0;
          overflow  <= 1'b0;
          if (is_star) begin
            is_star_pressed <= 1'b1;
          end else if (program_en) begin
            if (sub_ok) begin
              stored     <= entry_buf;
              initialize <= 1'b1;
              fail_cnt   <= '0;
            end else begin
              wrong <= 1'b1;
            end
          end else if (sub_ok && match) begin
            correct  <= 1'b1;
            fail_cnt <= '0;
          end else begin
            wrong    <= 1'b1;
            fail_cnt <= fail_next;
            if (lock_now) begin
              state <= lock_pkg::LOCKED;
            end
          end
        end
      end
    end
  end

  lockout_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (lock_now),
    .done (lock_done)
  );

  assign lockout   = (state == lock_pkg::LOCKED);
  assign digit_cnt = cnt;

endmodule

// File: tb/tb_passcode_checker.sv
// tb/tb_passcode_checker.sv - scoreboard bench for passcode_checker with a queue-based reference model
module tb_passcode_checker;

  localparam int CODE_LEN = 4;
  localparam int MAX_FAIL = 3;
  localparam int LOCK     = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       is_on = 1'b1;
  logic       program_en = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       is_star_pressed, correct, initialize, wrong, lockout;
  logic [3:0] digit_cnt;

  passcode_checker #(
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .is_on          (is_on),
    .program_en     (program_en),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .is_star_pressed(is_star_pressed),
    .correct        (correct),
    .initialize     (initialize),
    .wrong          (wrong),
    .lockout        (lockout),
    .digit_cnt      (digit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit star;
    bit cor;
    bit init;
    bit wrong;
    bit lock;
    int dcnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   lock_run = 0;
  bit   key_seen = 1'b0;

  // Reference model: entry as a list of digits, passcode as a list of digits
  int m_buf[$];
  int m_stored[$];
  bit m_ovf;
  int m_fail;
  int m_lock_left;
  bit m_prev_on;

  task automatic model_reset();
    m_buf.delete();
    m_stored = '{1, 2, 3, 4};
    m_ovf = 1'b0;
    m_fail = 0;
    m_lock_left = 0;
    m_prev_on = 1'b0;
  endtask

  function automatic bit same_code();
    if (m_buf.size() != m_stored.size()) return 1'b0;
    foreach (m_buf[i]) if (m_buf[i] != m_stored[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock edge worth of model behaviour; pushes an expectation per key strobe
  task automatic model_step(input bit kv, input int kc);
    exp_t e;
    bit   locked;
    e = '{star: 0, cor: 0, init: 0, wrong: 0, lock: 0, dcnt: 0};
    locked = (m_lock_left > 0);
    if (locked) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end
    if (m_prev_on && !is_on) begin
      m_buf.delete();
      m_ovf = 1'b0;
    end
    m_prev_on = is_on;
    if (kv && is_on && !locked && kc < 12) begin
      if (kc < 10) begin
        if (m_buf.size() < CODE_LEN) m_buf.push_back(kc);
        else m_ovf = 1'b1;
      end else if (kc == 10) begin
        e.star = 1'b1;
        m_buf.delete();
        m_ovf = 1'b0;
      end else begin
        bit full_ok;
        full_ok = (m_buf.size() == CODE_LEN) && !m_ovf;
        if (program_en) begin
          if (full_ok) begin
            m_stored = m_buf;
            e.init = 1'b1;
            m_fail = 0;
          end else begin
            e.wrong = 1'b1;
          end
        end else if (full_ok && same_code()) begin
          e.cor = 1'b1;
          m_fail = 0;
        end else begin
          e.wrong = 1'b1;
          if (m_fail < MAX_FAIL) m_fail++;
          if (m_fail == MAX_FAIL) m_lock_left = LOCK;
        end
        m_buf.delete();
        m_ovf = 1'b0;
      end
    end
    if (kv) begin
      e.lock = (m_lock_left > 0);
      e.dcnt = m_buf.size();
      exp_q.push_back(e);
    end
  endtask

  // Drive one cycle starting just after a falling edge; returns at the next falling edge
  task automatic cycle(input bit kv, input int kc);
    key_valid = kv;
    key_code  = 4'(kc);
    model_step(kv, kc);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press(input int kc);
    cycle(1'b1, kc);
    cycle(1'b0, 0);
  endtask

  task automatic press_code(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d); press(11);
  endtask

  // Async reset mid-cycle: outputs must drop without waiting for a clock
  task automatic do_reset(input string name);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({is_star_pressed, correct, initialize, wrong, lockout} != 5'b0 || digit_cnt != 4'd0) begin
      fails++;
      $display("FAIL %s: outputs star/cor/init/wrong/lock=%b%b%b%b%b cnt=%0d, required all 0",
               name, is_star_pressed, correct, initialize, wrong, lockout, digit_cnt);
    end
    model_reset();
    lock_run = 0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // Monitor: sample key strobes as the DUT sees them
  always @(posedge clk) key_seen = key_valid;

  // Monitor: pop and compare one expectation per sampled key, otherwise require silence
  always @(negedge clk) begin
    exp_t e;
    if (key_seen) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: DUT saw a key with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if (is_star_pressed != e.star || correct != e.cor || initialize != e.init ||
            wrong != e.wrong || lockout != e.lock || int'(digit_cnt) != e.dcnt) begin
          fails++;
          $display("FAIL key_response @%0t: got star/cor/init/wrong/lock=%b%b%b%b%b cnt=%0d, required %b%b%b%b%b cnt=%0d",
                   $time, is_star_pressed, correct, initialize, wrong, lockout, digit_cnt,
                   e.star, e.cor, e.init, e.wrong, e.lock, e.dcnt);
        end
      end
    end else if (reset) begin
      tests++;
      if (is_star_pressed || correct || initialize || wrong) begin
        fails++;
        $display("FAIL idle_pulse @%0t: got star/cor/init/wrong=%b%b%b%b, required 0000",
                 $time, is_star_pressed, correct, initialize, wrong);
      end
    end
    if (lockout) begin
      lock_run++;
    end else if (lock_run != 0) begin
      tests++;
      if (lock_run != LOCK) begin
        fails++;
        $display("FAIL lockout_length: got %0d cycles, required %0d", lock_run, LOCK);
      end
      lock_run = 0;
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    tests++;
    if ({is_star_pressed, correct, initialize, wrong, lockout} != 5'b0 || digit_cnt != 4'd0) begin
      fails++;
      $display("FAIL reset_state: outputs=%b%b%b%b%b cnt=%0d, required all 0",
               is_star_pressed, correct, initialize, wrong, lockout, digit_cnt);
    end
    @(negedge clk);
    #2 reset = 1'b1;

    // Correct default code
    cycle(1'b0, 0);
    press_code(1, 2, 3, 4);

    // Short entry then overflow entry, then a third wrong to lock
    press(1); press(2); press(3); press(11);
    press(1); press(2); press(3); press(4); press(5); press(11);
    press(11);
    for (int i = 0; i < LOCK + 4; i++) cycle((i % 3) == 0, i % 10);
    press_code(1, 2, 3, 4);

    // Star clears a partial entry
    press(5); press(6); press(10);
    press_code(1, 2, 3, 4);

    // Program a new code, old code now wrong, new code correct
    program_en = 1'b1;
    press_code(9, 8, 7, 6);
    program_en = 1'b0;
    press_code(1, 2, 3, 4);
    press_code(9, 8, 7, 6);

    // Reserved codes ignored, back-to-back keys
    cycle(1'b1, 12); cycle(1'b1, 15); cycle(1'b1, 9); cycle(1'b1, 8); cycle(1'b1, 7);
    cycle(1'b1, 6); cycle(1'b1, 11); cycle(1'b0, 0);

    // Reset mid-entry reverts the stored code
    press(1); press(2);
    do_reset("reset_mid_entry");
    press_code(1, 2, 3, 4);

    // Reset mid-lockout
    press(11); press(11); press(11);
    for (int i = 0; i < 10; i++) cycle(1'b0, 0);
    do_reset("reset_mid_lockout");
    press_code(1, 2, 3, 4);

    // Keys while powered down, and power-down discarding a partial entry
    is_on = 1'b0;
    press(1); press(10); press(11);
    is_on = 1'b1;
    press(1); press(2);
    is_on = 1'b0;
    cycle(1'b0, 0);
    is_on = 1'b1;
    press_code(1, 2, 3, 4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      int kc;
      if ($urandom_range(0, 99) < 2) is_on = ~is_on;
      if ($urandom_range(0, 99) < 3) program_en = ~program_en;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        if (m_buf.size() < CODE_LEN && $urandom_range(0, 2) != 0) kc = m_stored[m_buf.size()];
        else kc = $urandom_range(0, 9);
        cycle(1'b1, kc);
      end else if (r < 60) begin
        cycle(1'b1, 10);
      end else if (r < 75) begin
        cycle(1'b1, 11);
      end else if (r < 80) begin
        cycle(1'b1, $urandom_range(12, 15));
      end else begin
        cycle(1'b0, 0);
      end
    end
    is_on = 1'b1;
    program_en = 1'b0;
    for (int i = 0; i < LOCK + 4; i++) cycle(1'b0, 0);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
